// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT types and widths for the scheduler and datapath.
package fft_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DRAIN} state_t;
    localparam int CPLX_W = 34;
    localparam int VEC_W  = 4 * CPLX_W;
    localparam int ROT_W  = 3;
endpackage

// File: rtl/fft_sched.sv
// fft_sched: sequences s_p -> butterfly passes -> p_s for one frame, with one-deep queue.
module fft_sched import fft_pkg::*; #(
    parameter int NUM_STAGES = 3,
    parameter int PS_CYCLES  = 4,
    parameter int ROT_BASE   = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             s_p_flag_in,
    input  logic             clr_ovr,
    output logic             mux_flag,
    output logic [ROT_W-1:0] rotation,
    output logic             reg_flag,
    output logic             p_s_flag,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int DW = (PS_CYCLES > 1) ? $clog2(PS_CYCLES) : 1;

    if (NUM_STAGES < 2 || PS_CYCLES < 1) begin : g_bad_param
        $error("fft_sched: NUM_STAGES must be >= 2 and PS_CYCLES >= 1");
    end

    state_t state, state_nx;
    logic [SW-1:0] stage_cnt, stage_nx;
    logic [DW-1:0] drain_cnt, drain_nx;
    logic [CNT_W-1:0] frame_cnt_nx;
    logic pending, pending_nx, overrun_nx;
    logic acc, last_stage, last_drain;

    assign acc        = enable & s_p_flag_in;
    assign last_stage = stage_cnt == SW'(NUM_STAGES - 1);
    assign last_drain = drain_cnt == DW'(PS_CYCLES - 1);

    assign mux_flag   = (state == CALC) && (stage_cnt != '0);
    assign rotation   = (state == CALC) ? ROT_W'(ROT_BASE + int'(stage_cnt)) : '0;
    assign reg_flag   = (state == CALC) && !last_stage;
    assign p_s_flag   = (state == CALC) && last_stage;
    assign busy       = state != IDLE;
    assign frame_done = (state == DRAIN) && last_drain;

    always_comb begin
        state_nx     = state;
        stage_nx     = stage_cnt;
        drain_nx     = drain_cnt;
        frame_cnt_nx = frame_cnt;
        pending_nx   = pending;
        overrun_nx   = overrun & ~clr_ovr;
        // A second frame arriving while one is already queued is dropped
        if (busy && acc) begin
            if (pending)
                overrun_nx = 1'b1;
            else
                pending_nx = 1'b1;
        end
        case (state)
            IDLE: begin
                if (acc) begin
                    state_nx = CALC;
                    stage_nx = '0;
                end
            end
            CALC: begin
                if (last_stage) begin
                    state_nx = DRAIN;
                    drain_nx = '0;
                end else begin
                    stage_nx = stage_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    frame_cnt_nx = frame_cnt + 1'b1;
                    state_nx     = (pending || acc) ? CALC : IDLE;
                    stage_nx     = '0;
                    // The queued frame starts now; a fresh arrival takes its slot
                    pending_nx   = pending & acc;
                    overrun_nx   = overrun & ~clr_ovr;
                end else begin
                    drain_nx = drain_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage_cnt <= '0;
            drain_cnt <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nx;
            stage_cnt <= stage_nx;
            drain_cnt <= drain_nx;
            pending   <= pending_nx;
            overrun   <= overrun_nx;
            frame_cnt <= frame_cnt_nx;
        end
    end
endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched: directed checks of frame sequencing, queueing, overrun and reset.
module tb_fft_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic s_p_flag_in = 1'b0;
    logic clr_ovr = 1'b0;
    logic mux_flag, reg_flag, p_s_flag, busy, frame_done, overrun;
    logic [2:0] rotation;
    logic [15:0] frame_cnt;
    logic [7:0] o;
    logic [7:0] calc_exp [3];
    int n_checks = 0;
    int n_fail = 0;

    fft_sched dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_p_flag_in(s_p_flag_in),
        .clr_ovr(clr_ovr), .mux_flag(mux_flag), .rotation(rotation),
        .reg_flag(reg_flag), .p_s_flag(p_s_flag), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    assign o = {mux_flag, rotation, reg_flag, p_s_flag, busy, frame_done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_p_flag_in = 1'b0;
        clr_ovr = 1'b0;
        enable = 1'b1;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o !== 8'h00 || overrun !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got o=%h ovr=%b cnt=%0d, expected 00/0/0", o, overrun, frame_cnt);
        end
        s_p_flag_in = 1'b1;
        step();
        s_p_flag_in = 1'b0;
        n_checks++;
        if (o !== calc_exp[0]) begin
            n_fail++;
            $display("FAIL reset_pre: got %h expected %h", o, calc_exp[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 00", o);
        end
        #2 rst_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b o=%h expected 0/00", busy, o);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_o;
        do_reset();
        s_p_flag_in = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            s_p_flag_in = 1'b0;
            exp_o = (c <= 3) ? calc_exp[c-1] : (c < 7) ? 8'h02 : (c == 7) ? 8'h03 : 8'h00;
            n_checks++;
            if (o !== exp_o) begin
                n_fail++;
                $display("FAIL single_c%0d: got %h expected %h", c, o, exp_o);
            end
        end
        n_checks++;
        if (frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL single_cnt: got %0d expected 1", frame_cnt);
        end
    endtask

    task automatic test_back_to_back(input int v);
        int cyc;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            s_p_flag_in = (c == 0 || c == v);
            step();
            cyc = c + 1;
            if (cyc >= 8 && cyc <= 10) begin
                n_checks++;
                if (o !== calc_exp[cyc-8]) begin
                    n_fail++;
                    $display("FAIL b2b%0d_c%0d: got %h expected %h", v, cyc, o, calc_exp[cyc-8]);
                end
            end
            if (cyc == 14) begin
                n_checks++;
                if (frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b%0d_done: got %b expected 1", v, frame_done);
                end
            end
        end
        s_p_flag_in = 1'b0;
        n_checks++;
        if (frame_cnt !== 16'd2 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b%0d_end: got cnt=%0d busy=%b ovr=%b expected 2/0/0", v, frame_cnt, busy, overrun);
        end
    endtask

    task automatic test_overrun();
        int cyc;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            s_p_flag_in = (c == 0 || c == 2 || c == 3);
            step();
            cyc = c + 1;
            if (cyc == 3 || cyc == 4) begin
                n_checks++;
                if (overrun !== (cyc == 4)) begin
                    n_fail++;
                    $display("FAIL ovr_set_c%0d: got %b expected %b", cyc, overrun, cyc == 4);
                end
            end
            if (cyc == 8) begin
                n_checks++;
                if (o !== calc_exp[0]) begin
                    n_fail++;
                    $display("FAIL ovr_pend_run: got %h expected %h", o, calc_exp[0]);
                end
            end
            if (cyc == 16) begin
                n_checks++;
                if (busy !== 1'b0 || frame_cnt !== 16'd2) begin
                    n_fail++;
                    $display("FAIL ovr_frames: got busy=%b cnt=%0d expected 0/2", busy, frame_cnt);
                end
            end
        end
        s_p_flag_in = 1'b0;
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        s_p_flag_in = 1'b1;
        step();
        step();
        clr_ovr = 1'b1;
        step();
        s_p_flag_in = 1'b0;
        clr_ovr = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_priority: got %b expected 1", overrun);
        end
    endtask

    task automatic test_enable();
        int cyc;
        do_reset();
        enable = 1'b0;
        s_p_flag_in = 1'b1;
        step();
        s_p_flag_in = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL en_gate: got busy=%b ovr=%b expected 0/0", busy, overrun);
        end
        for (int c = 0; c < 15; c++) begin
            enable = (c != 2);
            s_p_flag_in = (c <= 2);
            step();
            cyc = c + 1;
            if (cyc == 8) begin
                n_checks++;
                if (o !== calc_exp[0] || overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL en_pend: got o=%h ovr=%b expected %h/0", o, overrun, calc_exp[0]);
                end
            end
        end
        enable = 1'b1;
        s_p_flag_in = 1'b0;
        n_checks++;
        if (frame_cnt !== 16'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_frames: got cnt=%0d busy=%b expected 2/0", frame_cnt, busy);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic seen;
        do_reset();
        s_p_flag_in = 1'b1;
        step();
        step();
        s_p_flag_in = 1'b0;
        n_checks++;
        if (o !== calc_exp[1]) begin
            n_fail++;
            $display("FAIL midrst_pre: got %h expected %h", o, calc_exp[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_out: got %h expected 00", o);
        end
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            seen |= busy | frame_done;
        end
        n_checks++;
        if (seen !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_after: got activity=%b cnt=%0d expected 0/0", seen, frame_cnt);
        end
    endtask

    initial begin
        calc_exp[0] = 8'h0A;
        calc_exp[1] = 8'h9A;
        calc_exp[2] = 8'hA6;
        test_reset();
        test_single();
        test_back_to_back(4);
        test_back_to_back(7);
        test_overrun();
        test_enable();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
